// File: rtl/serial_pin_share.sv
// serial_pin_share: time-multiplexes one shared pad group and one register
// bus between NPER peripherals. Only one peripheral owns the pads at a time.
// Changing owner goes through DRAIN, where the old owner finishes its work,
// and then PARK, where the pads are released for GUARD cycles.
module serial_pin_share #(
  parameter int             NPER    = 2,
  parameter int             PW      = 2,
  parameter int             DW      = 8,
  parameter int             GUARD   = 4,
  parameter int             TMO     = 16,
  parameter logic [PW-1:0]  IDLE_IN = '1,
  localparam int            SW      = $clog2(NPER)
) (
  input  logic               app_clk,
  input  logic               app_rst,
  input  logic [SW-1:0]      sel_req,
  output logic [SW-1:0]      sel_cur,
  output logic               switching,
  input  logic [NPER-1:0]    per_busy,
  input  logic               reg_cs,
  input  logic               reg_wr,
  input  logic [3:0]         reg_addr,
  input  logic [DW-1:0]      reg_wdata,
  input  logic               reg_be,
  output logic [DW-1:0]      reg_rdata,
  output logic               reg_ack,
  output logic               reg_err,
  output logic [NPER-1:0]    per_cs,
  output logic               per_wr,
  output logic [3:0]         per_addr,
  output logic [DW-1:0]      per_wdata,
  output logic               per_be,
  input  logic [NPER*DW-1:0] per_rdata,
  input  logic [NPER-1:0]    per_ack,
  input  logic [NPER*PW-1:0] per_io_out,
  input  logic [NPER*PW-1:0] per_io_oeb,
  output logic [NPER*PW-1:0] per_io_in,
  input  logic [PW-1:0]      io_in,
  output logic [PW-1:0]      io_out,
  output logic [PW-1:0]      io_oeb
);

  localparam int             CMAX       = (TMO > GUARD) ? TMO : GUARD;
  localparam int             CW         = $clog2(CMAX) + 1;
  localparam logic [CW-1:0]  TMO_LAST   = CW'(TMO - 1);
  localparam logic [CW-1:0]  GUARD_LOAD = CW'(GUARD - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_DRAIN,
    ST_PARK
  } state_t;

  state_t          state;
  logic [SW-1:0]   sel_nxt;
  logic [CW-1:0]   drain_cnt;
  logic [CW-1:0]   guard_cnt;
  logic [CW-1:0]   bus_tmr;
  logic            txn_open;
  logic            park_ack_q;

  logic            own_ack;
  logic            own_busy;
  logic [DW-1:0]   own_rdata;
  logic [PW-1:0]   own_out;
  logic [PW-1:0]   own_oeb;

  logic            active;
  logic            pads_live;
  logic            bus_block;
  logic            tmo_hit;
  logic            cs_live;
  logic            ack_hit;
  logic            sel_ok;
  logic            go_drain;

  // Register strobes other than chip-select fan out to every peripheral.
  assign per_wr    = reg_wr;
  assign per_addr  = reg_addr;
  assign per_wdata = reg_wdata;
  assign per_be    = reg_be;

  // When every code of sel_req names a real peripheral, no range check is needed.
  if (NPER == (1 << SW)) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    assign sel_ok = (int'(sel_req) < NPER);
  end

  // Bus and pads are only live outside reset; DRAIN keeps the old owner's pads.
  assign active    = (state == ST_ACTIVE) && !app_rst;
  assign pads_live = ((state == ST_ACTIVE) || (state == ST_DRAIN)) && !app_rst;
  assign bus_block = txn_open || park_ack_q;
  assign tmo_hit   = active && reg_cs && !bus_block && (bus_tmr == TMO_LAST);
  assign cs_live   = active && reg_cs && !bus_block && !tmo_hit;
  assign ack_hit   = cs_live && own_ack;
  assign go_drain  = active && sel_ok && (sel_req != sel_cur) && !reg_cs && !bus_block;

  // Pick out the current owner's slice of every per-peripheral input.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    own_ack   = 1'b0;
    own_busy  = 1'b0;
    own_rdata = '0;
    own_out   = '0;
    own_oeb   = '1;
    for (int i = 0; i < NPER; i++) begin
      if (sel_cur == SW'(i)) begin
        own_ack   = per_ack[i];
        own_busy  = per_busy[i];
        own_rdata = per_rdata[i*DW +: DW];
        own_out   = per_io_out[i*PW +: PW];
        own_oeb   = per_io_oeb[i*PW +: PW];
      end
    end
  end

  // Route pads, chip-selects and the bus response for the current owner.
  always_comb begin
    io_out    = '0;
    io_oeb    = '1;
    per_io_in = {NPER{IDLE_IN}};
    per_cs    = '0;
    if (pads_live) begin
      io_out = own_out;
      io_oeb = own_oeb;
    end
    for (int i = 0; i < NPER; i++) begin
      if (sel_cur == SW'(i)) begin
        per_cs[i] = cs_live;
        if (pads_live) per_io_in[i*PW +: PW] = io_in;
      end
    end
    reg_ack   = ack_hit || tmo_hit || (park_ack_q && !app_rst);
    reg_err   = tmo_hit || (park_ack_q && !app_rst);
    reg_rdata = '0;
    if (ack_hit)      reg_rdata = own_rdata;
    else if (tmo_hit) reg_rdata = '1;
  end

  // Owner FSM plus bus transaction tracking, synchronous reset.
  always_ff @(posedge app_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (app_rst) begin
      state      <= ST_PARK;
      guard_cnt  <= GUARD_LOAD;
      drain_cnt  <= '0;
      bus_tmr    <= '0;
      txn_open   <= 1'b0;
      park_ack_q <= 1'b0;
      sel_cur    <= '0;
      sel_nxt    <= '0;
      switching  <= 1'b1;
    end else begin
      // A transaction stays open from its ack until chip-select drops.
      if (!reg_cs) begin
        txn_open <= 1'b0;
        bus_tmr  <= '0;
      end else if (reg_ack) begin
        txn_open <= 1'b1;
        bus_tmr  <= '0;
      end else if (active && !bus_block) begin
        bus_tmr  <= bus_tmr + CW'(1);
      end

      // Accesses while the pads are changing hands get an error one cycle later.
      park_ack_q <= (state != ST_ACTIVE) && reg_cs && !bus_block;

      case (state)
        ST_ACTIVE: begin
          if (go_drain) begin
            state     <= ST_DRAIN;
            sel_nxt   <= sel_req;
            drain_cnt <= '0;
            switching <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!own_busy || (drain_cnt == TMO_LAST)) begin
            state     <= ST_PARK;
            sel_cur   <= sel_nxt;
            guard_cnt <= GUARD_LOAD;
          end else begin
            drain_cnt <= drain_cnt + CW'(1);
          end
        end
        ST_PARK: begin
          if (guard_cnt == '0) begin
            state     <= ST_ACTIVE;
            switching <= 1'b0;
          end else begin
            guard_cnt <= guard_cnt - CW'(1);
          end
        end
        default: begin
          state     <= ST_PARK;
          guard_cnt <= GUARD_LOAD;
          switching <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pin_share.sv
// Bench for serial_pin_share: directed owner-switch, timeout and park-access
// scenarios, then random traffic compared every cycle against a model built
// from the ownership and bus rules.
module tb_serial_pin_share;

  localparam int NPER  = 3;
  localparam int PW    = 2;
  localparam int DW    = 8;
  localparam int GUARD = 4;
  localparam int TMO   = 16;
  localparam int SW    = 2;
  localparam logic [PW-1:0] IDLE = 2'b11;

  localparam int M_ACTIVE = 0;
  localparam int M_DRAIN  = 1;
  localparam int M_PARK   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [SW-1:0]       sel_req;
  logic [SW-1:0]       sel_cur;
  logic                switching;
  logic [NPER-1:0]     per_busy;
  logic                reg_cs, reg_wr, reg_be;
  logic [3:0]          reg_addr;
  logic [DW-1:0]       reg_wdata;
  logic [DW-1:0]       reg_rdata;
  logic                reg_ack, reg_err;
  logic [NPER-1:0]     per_cs;
  logic                per_wr, per_be;
  logic [3:0]          per_addr;
  logic [DW-1:0]       per_wdata;
  logic [NPER*DW-1:0]  per_rdata;
  logic [NPER-1:0]     per_ack;
  logic [NPER*PW-1:0]  per_io_out, per_io_oeb, per_io_in;
  logic [PW-1:0]       io_in, io_out, io_oeb;

  always #5 clk = ~clk;

  serial_pin_share #(
    .NPER(NPER), .PW(PW), .DW(DW), .GUARD(GUARD), .TMO(TMO)
  ) dut (
    .app_clk(clk), .app_rst(rst),
    .sel_req(sel_req), .sel_cur(sel_cur), .switching(switching),
    .per_busy(per_busy),
    .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_be(reg_be),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .reg_err(reg_err),
    .per_cs(per_cs), .per_wr(per_wr), .per_addr(per_addr),
    .per_wdata(per_wdata), .per_be(per_be),
    .per_rdata(per_rdata), .per_ack(per_ack),
    .per_io_out(per_io_out), .per_io_oeb(per_io_oeb), .per_io_in(per_io_in),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the pads, how long each phase has left,
  // and where the current bus access stands.
  int  m_mode, m_owner, m_next, m_park_left, m_drain_seen, m_wait;
  bit  m_done, m_late, m_valid = 1'b0;

  logic                e_ack, e_err, e_sw;
  logic [DW-1:0]       e_rdata;
  logic [NPER-1:0]     e_cs;
  logic [PW-1:0]       e_io_out, e_io_oeb;
  logic [NPER*PW-1:0]  e_per_in;

  task automatic model_eval();
    bit act, live, open, tmo, cs_ok, ok_ack;
    act    = (m_mode == M_ACTIVE) && !rst;
    live   = (m_mode != M_PARK) && !rst;
    open   = m_done || m_late;
    tmo    = act && reg_cs && !open && (m_wait == TMO - 1);
    cs_ok  = act && reg_cs && !open && !tmo;
    ok_ack = cs_ok && per_ack[m_owner];
    e_ack  = ok_ack || tmo || (m_late && !rst);
    e_err  = tmo || (m_late && !rst);
    e_rdata = ok_ack ? per_rdata[m_owner*DW +: DW] : (tmo ? 8'hFF : 8'h00);
    e_cs = '0;
    if (cs_ok) e_cs[m_owner] = 1'b1;
    e_io_out = live ? per_io_out[m_owner*PW +: PW] : 2'b00;
    e_io_oeb = live ? per_io_oeb[m_owner*PW +: PW] : 2'b11;
    e_per_in = {NPER{IDLE}};
    if (live) e_per_in[m_owner*PW +: PW] = io_in;
    e_sw = (m_mode != M_ACTIVE);
  endtask

  task automatic model_advance();
    bit open, late_n;
    model_eval();
    if (rst) begin
      m_mode = M_PARK; m_park_left = GUARD; m_owner = 0; m_next = 0;
      m_done = 1'b0; m_late = 1'b0; m_wait = 0; m_drain_seen = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      open   = m_done || m_late;
      late_n = (m_mode != M_ACTIVE) && reg_cs && !open;
      if (!reg_cs) begin
        m_done = 1'b0; m_wait = 0;
      end else if (e_ack) begin
        m_done = 1'b1; m_wait = 0;
      end else if (m_mode == M_ACTIVE && !open) begin
        m_wait++;
      end
      m_late = late_n;
      if (m_mode == M_ACTIVE) begin
        if (int'(sel_req) < NPER && int'(sel_req) != m_owner && !reg_cs && !open) begin
          m_mode = M_DRAIN; m_next = int'(sel_req); m_drain_seen = 0;
        end
      end else if (m_mode == M_DRAIN) begin
        m_drain_seen++;
        if (!per_busy[m_owner] || m_drain_seen >= TMO) begin
          m_mode = M_PARK; m_owner = m_next; m_park_left = GUARD;
        end
      end else begin
        m_park_left--;
        if (m_park_left == 0) m_mode = M_ACTIVE;
      end
    end
  endtask

  task automatic compare_all();
    model_eval();
    check("ack", reg_ack, e_ack);
    check("err", reg_err, e_err);
    if (e_ack) check("rdata", reg_rdata, e_rdata);
    check("per_cs", per_cs, e_cs);
    check("io_out", io_out, e_io_out);
    check("io_oeb", io_oeb, e_io_oeb);
    check("per_io_in", per_io_in, e_per_in);
    check("switching", switching, e_sw);
    check("sel_cur", sel_cur, m_owner);
    check("bc_wdata", per_wdata, reg_wdata);
    check("bc_addr", per_addr, reg_addr);
  endtask

  // One clock cycle: compare mid-cycle, then clock the model with the same inputs.
  task automatic step();
    #2;
    if (m_valid) compare_all();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first;
    rst = 1'b1; sel_req = '0; per_busy = '0;
    reg_cs = 1'b0; reg_wr = 1'b0; reg_be = 1'b1; reg_addr = '0; reg_wdata = '0;
    per_rdata = '0; per_ack = '0; io_in = 2'b01;
    per_io_out = 6'b11_01_10; per_io_oeb = '0;

    // Reset: pads parked, no ack, switching high.
    step(); step();
    check("rst_switching", switching, 1'b1);
    check("rst_ack", reg_ack, 1'b0);
    check("rst_cs", per_cs, '0);
    check("rst_oeb", io_oeb, 2'b11);
    check("rst_out", io_out, 2'b00);

    // Release: GUARD parked cycles, then owner 0 on the pads.
    rst = 1'b0;
    for (int k = 0; k < GUARD; k++) begin
      #1;
      check("rel_park_oeb", io_oeb, 2'b11);
      step();
    end
    #1;
    check("rel_act_oeb", io_oeb, 2'b00);
    check("rel_act_out", io_out, 2'b10);
    check("rel_act_sw", switching, 1'b0);
    check("rel_act_in0", per_io_in, 6'b11_11_01);

    // Switch 0->1 with owner 0 busy for two drain cycles.
    per_busy = 3'b001; sel_req = 2'd1;
    step();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) per_busy = 3'b000;
      #1;
      check("drain_pads", io_out, 2'b10);
      check("drain_sw", switching, 1'b1);
      step();
    end
    for (int k = 0; k < GUARD; k++) begin
      #1;
      check("sw_park_oeb", io_oeb, 2'b11);
      check("sw_park_in", per_io_in, 6'b11_11_11);
      check("sw_park_sel", sel_cur, 2'd1);
      step();
    end
    #1;
    check("sw_act_sw", switching, 1'b0);
    check("sw_act_in", per_io_in, 6'b11_01_11);
    check("sw_act_out", io_out, 2'b01);

    // Drain timeout: owner 1 never goes idle.
    per_busy = 3'b111; sel_req = 2'd2;
    step();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (io_oeb === 2'b11) break;
      n++;
      step();
    end
    check("drain_tmo_len", n, TMO);
    for (int k = 0; k < GUARD; k++) step();
    per_busy = '0;
    #1;
    check("tmo_new_owner", sel_cur, 2'd2);
    check("tmo_new_out", io_out, 2'b11);

    // Bus timeout: owner never acks.
    reg_cs = 1'b1; reg_addr = 4'h3; per_ack = '0;
    first = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c == 0) check("bto_cs_first", per_cs, 3'b100);
      if (reg_ack && first < 0) begin
        first = c;
        check("bto_err", reg_err, 1'b1);
        check("bto_rdata", reg_rdata, 8'hFF);
      end else if (c > 15) begin
        check("bto_no_reack", reg_ack, 1'b0);
      end
      if (c >= 15) check("bto_cs_low", per_cs, '0);
      step();
    end
    check("bto_cycle", first, 15);
    reg_cs = 1'b0;
    step();

    // Access while parked gets a registered error.
    sel_req = 2'd0;
    step();
    #1;
    check("pk_drain_sw", switching, 1'b1);
    step();
    reg_cs = 1'b1;
    #1;
    check("pk_ack_early", reg_ack, 1'b0);
    check("pk_cs0", per_cs, '0);
    step();
    #1;
    check("pk_ack", reg_ack, 1'b1);
    check("pk_err", reg_err, 1'b1);
    check("pk_rdata", reg_rdata, 8'h00);
    check("pk_cs1", per_cs, '0);
    reg_cs = 1'b0;
    step(); step(); step();
    #1;
    check("pk_back_sel", sel_cur, 2'd0);
    check("pk_back_sw", switching, 1'b0);

    // Out-of-range request is ignored.
    sel_req = 2'd3;
    for (int k = 0; k < 6; k++) begin
      step();
      #1;
      check("bad_sel_sw", switching, 1'b0);
      check("bad_sel_cur", sel_cur, 2'd0);
    end

    // Request and access in the same cycle: access served, switch deferred.
    per_rdata = {8'h33, 8'h22, 8'h5A}; per_ack = 3'b001;
    reg_cs = 1'b1; sel_req = 2'd1;
    #1;
    check("same_ack", reg_ack, 1'b1);
    check("same_err", reg_err, 1'b0);
    check("same_rdata", reg_rdata, 8'h5A);
    check("same_cs", per_cs, 3'b001);
    step();
    per_ack = '0;
    #1;
    check("same_sw_held", switching, 1'b0);
    check("same_cs_masked", per_cs, '0);
    step();
    reg_cs = 1'b0;
    step();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (sel_cur === 2'd1 && switching === 1'b0) break;
      n++;
      step();
    end
    check("same_switch_done", (n < 20), 1'b1);

    // Random traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 7) == 0) reg_cs = ~reg_cs;
      reg_wr    = 1'($urandom);
      reg_be    = 1'($urandom);
      reg_addr  = 4'($urandom);
      reg_wdata = 8'($urandom);
      for (int i = 0; i < NPER; i++) per_ack[i] = ($urandom_range(0, 19) == 0);
      per_rdata = 24'($urandom);
      if ($urandom_range(0, 15) == 0) per_busy = 3'($urandom);
      if ($urandom_range(0, 29) == 0) sel_req = 2'($urandom_range(0, 3));
      per_io_out = 6'($urandom);
      per_io_oeb = 6'($urandom);
      io_in      = 2'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
